fpu_op_sequencer: RTL and testbench
===================================

// Module: fpu_op_sequencer
// PURPOSE
// - Single-issue controller in front of the FP add/sub/mul/div datapath and the exception handler.
// - Accepts one operation over a valid/ready handshake and registers the operands.
// - Screens the operation through the exception handler; on an exception, returns its result directly.
// - Otherwise starts the selected arithmetic unit, waits for done and returns the unit result.
// PARAMETERS
// - DATA_WIDTH     32   operand/result width (IEEE-754 single)
// - OP_WIDTH       2    opcode width; 00 add, 01 sub, 10 mul, 11 div
// - CNT_WIDTH      16   width of the completed-op and exception counters
// - TIMEOUT_CYCLES 64   watchdog limit in WAIT (used only with FPU_SEQ_TIMEOUT_EN)
// PORTS
// - clk           in   1           clock, rising edge
// - rst           in   1           asynchronous reset, active-high
// - in_valid      in   1           request valid
// - in_ready      out  1           sequencer can accept (high only in IDLE)
// - float_num1    in   DATA_WIDTH  operand A
// - float_num2    in   DATA_WIDTH  operand B
// - opcode        in   OP_WIDTH    operation select
// - op_a/op_b     out  DATA_WIDTH  registered operands, to exception handler and units
// - op_code       out  OP_WIDTH    registered opcode, to exception handler mux and units
// - exc_sel       in   1           exception handler: exception detected
// - exc_out       in   DATA_WIDTH  exception handler: special-case result
// - unit_start    out  1           one-cycle start pulse to the selected unit
// - unit_done     in   1           selected unit: result valid
// - unit_result   in   DATA_WIDTH  selected unit result
// - out_valid     out  1           result valid; held until out_ready
// - out_ready     in   1           consumer accepts the result
// - result        out  DATA_WIDTH  final result
// - exc_flag      out  1           result came from the exception path
// - timeout_flag  out  1           result is a watchdog abort (0 when the macro is off)
// - op_count      out  CNT_WIDTH   completed ops, saturating
// - exc_count     out  CNT_WIDTH   exception-path ops, saturating
// BEHAVIOUR
// - FSM states: IDLE -> CHECK -> {DONE | EXEC -> WAIT -> DONE} -> IDLE.
// - IDLE: in_ready=1. On in_valid: register operands/opcode onto op_a/op_b/op_code, go to CHECK.
// - CHECK (1 cycle): sample exc_sel.
//   - exc_sel=1: result<=exc_out, exc_flag<=1, go to DONE.
//   - exc_sel=0: go to EXEC.
// - EXEC (1 cycle): unit_start=1, go to WAIT. unit_start is never high outside EXEC.
// - WAIT: on unit_done: result<=unit_result, exc_flag<=0, go to DONE.
//   - A unit_done sampled during EXEC is honoured the same way (zero-wait unit).
// - DONE: out_valid=1; result/flags stable. On out_ready: go to IDLE.
//   - No new request is accepted in DONE, even when out_ready is high.
// - Latency from handshake edge to out_valid:
//   - exception path: 2 cycles;
//   - unit path: 3 + unit wait cycles.
// - Throughput: one op at a time.
//   - Fastest back-to-back exception ops: 3 cycles, with out_ready held high.
// - Counters:
//   - op_count += 1 on each out_valid&&out_ready;
//   - exc_count += 1 when that accepted op has exc_flag=1.
//   - Both saturate at all-ones and never wrap.
// - unit_done outside EXEC/WAIT is ignored. op_a/op_b/op_code hold from capture until the next accept.
// - Reset (any time, including mid-op):
//   - FSM to IDLE;
//   - in_ready=1 once reset is released;
//   - out_valid, unit_start, exc_flag, timeout_flag = 0;
//   - result, op_a, op_b, op_code, op_count, exc_count = 0.
// CONFIGURATION
// - FPU_SEQ_TIMEOUT_EN defined:
//   - A wait counter clears on entry to WAIT and increments each WAIT cycle.
//   - If it reaches TIMEOUT_CYCLES with no unit_done: result<=32'h7FC00000 (qNaN), timeout_flag<=1, exc_flag<=0, go to DONE.
//   - unit_done arriving in that same cycle takes priority: normal result, timeout_flag=0.
// - FPU_SEQ_TIMEOUT_EN undefined:
//   - WAIT holds indefinitely until unit_done.
//   - timeout_flag is tied to 0 and no wait counter is built.
// TESTING
// - Exception path: add 7F800000 + FF800000 (+inf + -inf), exc_sel=1, exc_out=7FC00000.
//   - Required: out_valid 2 cycles after accept; result=7FC00000; exc_flag=1; unit_start never pulses.
// - Normal path: mul 40000000 * 40400000, exc_sel=0, unit_done 4 cycles after unit_start with 40C00000.
//   - Required: result=40C00000, exc_flag=0; exactly one unit_start pulse.
// - Backpressure: out_ready held low 5 cycles.
//   - Required: out_valid and result stable; in_ready=0; a new in_valid is not accepted until after out_ready.
// - Reset mid-WAIT: assert rst.
//   - Required: out_valid=0, unit_start=0, in_ready=1; a late unit_done is ignored; op_count unchanged (0).
// - Counter saturation, CNT_WIDTH=2: run 5 exception ops.
//   - Required: op_count=3, exc_count=3.
// - Watchdog (FPU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8): no unit_done.
//   - Required: result=7FC00000, timeout_flag=1 after 8 WAIT cycles.
//   - Without the macro: still in WAIT at cycle 100.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer
//
// Single-issue controller sitting in front of the FP add/sub/mul/div datapath
// and the IEEE-754 exception handler. One operation is accepted at a time:
// operands are registered, screened by the exception handler, and either the
// special-case result is returned directly or the selected arithmetic unit is
// started and its result returned once it signals done.
//
// Optional feature (compile-time macro):
//   FPU_SEQ_TIMEOUT_EN - builds a watchdog on the WAIT state. After
//                        TIMEOUT_CYCLES WAIT cycles without unit_done the op
//                        is aborted with a quiet NaN and timeout_flag set.
//                        Without the macro WAIT holds until unit_done and
//                        timeout_flag is tied low.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid / in_ready      request handshake (in_ready high only in IDLE)
//   float_num1/2, opcode     request operands and op (00 add 01 sub 10 mul 11 div)
//   op_a, op_b, op_code      registered operands/opcode to handler and units
//   exc_sel, exc_out         exception handler verdict and special result
//   unit_start               one-cycle start pulse to the selected unit
//   unit_done, unit_result   unit completion and its result
//   out_valid / out_ready    result handshake; result held until accepted
//   result                   final result
//   exc_flag                 result came from the exception path
//   timeout_flag             result is a watchdog abort
//   op_count, exc_count      saturating counts of accepted / exception results
// ---------------------------------------------------------------------------
module fpu_op_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int OP_WIDTH       = 2,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] float_num1,
  input  logic [DATA_WIDTH-1:0] float_num2,
  input  logic [OP_WIDTH-1:0]   opcode,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [OP_WIDTH-1:0]   op_code,
  input  logic                  exc_sel,
  input  logic [DATA_WIDTH-1:0] exc_out,
  output logic                  unit_start,
  input  logic                  unit_done,
  input  logic [DATA_WIDTH-1:0] unit_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  exc_flag,
  output logic                  timeout_flag,
  output logic [CNT_WIDTH-1:0]  op_count,
  output logic [CNT_WIDTH-1:0]  exc_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // A zero watchdog limit would make the WAIT compare meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fpu_op_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                 state_reg;
  logic                   in_ready_reg;
  logic                   out_valid_reg;
  logic                   unit_start_reg;
  logic                   exc_flag_reg;
  logic [DATA_WIDTH-1:0]  result_reg;
  logic [DATA_WIDTH-1:0]  op_a_reg;
  logic [DATA_WIDTH-1:0]  op_b_reg;
  logic [OP_WIDTH-1:0]    op_code_reg;
  logic [CNT_WIDTH-1:0]   op_count_reg;
  logic [CNT_WIDTH-1:0]   op_count_next;
  logic [CNT_WIDTH-1:0]   exc_count_reg;
  logic [CNT_WIDTH-1:0]   exc_count_next;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int WAIT_CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(32'h7FC0_0000);

  logic                      timeout_flag_reg;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_reg;
  logic                      wait_expired;

  // wait_cnt_reg counts completed WAIT cycles, so TIMEOUT_CYCLES-1 marks the
  // last WAIT cycle allowed before the abort.
  assign wait_expired = (wait_cnt_reg == WAIT_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_flag_reg;
`else
  assign timeout_flag = 1'b0;
`endif

  // Counters advance on the output handshake only, so the count reflects
  // results actually taken by the consumer. Both stick at all-ones.
  always_comb begin
    op_count_next  = op_count_reg;
    exc_count_next = exc_count_reg;
    if (out_valid_reg && out_ready) begin
      if (op_count_reg != CNT_MAX) begin
        op_count_next = op_count_reg + CNT_WIDTH'(1);
      end
      if (exc_flag_reg && (exc_count_reg != CNT_MAX)) begin
        exc_count_next = exc_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      unit_start_reg <= 1'b0;
      exc_flag_reg   <= 1'b0;
      result_reg     <= '0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_code_reg    <= '0;
      op_count_reg   <= '0;
      exc_count_reg  <= '0;
`ifdef FPU_SEQ_TIMEOUT_EN
      timeout_flag_reg <= 1'b0;
      wait_cnt_reg     <= '0;
`endif
    end else begin
      op_count_reg  <= op_count_next;
      exc_count_reg <= exc_count_next;

      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            op_a_reg     <= float_num1;
            op_b_reg     <= float_num2;
            op_code_reg  <= opcode;
            in_ready_reg <= 1'b0;
            state_reg    <= S_CHECK;
          end
        end

        // The handler sees the registered operands during this cycle.
        S_CHECK: begin
          if (exc_sel) begin
            result_reg    <= exc_out;
            exc_flag_reg  <= 1'b1;
`ifdef FPU_SEQ_TIMEOUT_EN
            timeout_flag_reg <= 1'b0;
`endif
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
            unit_start_reg <= 1'b1;
            state_reg      <= S_EXEC;
          end
        end

        // unit_start is high for exactly this cycle. A unit that answers in
        // the same cycle it is started skips WAIT entirely.
        S_EXEC: begin
          unit_start_reg <= 1'b0;
          if (unit_done) begin
            result_reg    <= unit_result;
            exc_flag_reg  <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
            timeout_flag_reg <= 1'b0;
`endif
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
`ifdef FPU_SEQ_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
            state_reg <= S_WAIT;
          end
        end

        // unit_done wins over an abort landing in the same cycle.
        S_WAIT: begin
          if (unit_done) begin
            result_reg    <= unit_result;
            exc_flag_reg  <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
            timeout_flag_reg <= 1'b0;
`endif
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end
`ifdef FPU_SEQ_TIMEOUT_EN
          else if (wait_expired) begin
            result_reg       <= QNAN;
            exc_flag_reg     <= 1'b0;
            timeout_flag_reg <= 1'b1;
            out_valid_reg    <= 1'b1;
            state_reg        <= S_DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_WIDTH'(1);
          end
`endif
        end

        // Result and flags are frozen here. A pending request is only taken
        // after returning to IDLE, which costs one cycle but keeps the
        // operand registers stable while the result is outstanding.
        S_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end

        default: begin
          out_valid_reg  <= 1'b0;
          unit_start_reg <= 1'b0;
          in_ready_reg   <= 1'b1;
          state_reg      <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign unit_start = unit_start_reg;
  assign exc_flag   = exc_flag_reg;
  assign result     = result_reg;
  assign op_a       = op_a_reg;
  assign op_b       = op_b_reg;
  assign op_code    = op_code_reg;
  assign op_count   = op_count_reg;
  assign exc_count  = exc_count_reg;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
`timescale 1ns/1ps
// Testbench for fpu_op_sequencer. The bench plays the exception handler and
// the arithmetic unit; the reference model tracks each op as a record
// (accept cycle, path, unit wait) and derives every expected output from the
// latency rules of the sequencer.
module tb_fpu_op_sequencer;

  localparam int DW    = 32;
  localparam int OW    = 2;
  localparam int CW    = 4;
  localparam int TOC   = 8;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int NEVER = -1;
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] float_num1;
  logic [DW-1:0] float_num2;
  logic [OW-1:0] opcode;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [OW-1:0] op_code;
  logic          exc_sel;
  logic [DW-1:0] exc_out;
  logic          unit_start;
  logic          unit_done;
  logic [DW-1:0] unit_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          exc_flag;
  logic          timeout_flag;
  logic [CW-1:0] op_count;
  logic [CW-1:0] exc_count;

  fpu_op_sequencer #(
    .DATA_WIDTH(DW), .OP_WIDTH(OW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .float_num1(float_num1), .float_num2(float_num2), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .exc_sel(exc_sel), .exc_out(exc_out),
    .unit_start(unit_start), .unit_done(unit_done), .unit_result(unit_result),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .exc_flag(exc_flag), .timeout_flag(timeout_flag),
    .op_count(op_count), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: the op in flight
  bit          busy;
  int          t_acc, t_out, m_w;
  bit          m_exc, m_to;
  logic [31:0] m_res, m_a, m_b, m_excout, m_ures;
  logic [1:0]  m_op;
  int          m_opc, m_excc, n_done, acc_gap;
  // Pending request
  bit          rq_v, rq_exc;
  logic [31:0] rq_a, rq_b, rq_excout, rq_ures;
  logic [1:0]  rq_op;
  int          rq_w;
  // Stimulus knobs and per-op observations
  int          ready_low_n;
  bit          rand_ready, force_done;
  int          obs_lat, obs_starts, obs_vcycles;
  bit          obs_seen, obs_exc, obs_to;
  logic [31:0] obs_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy = 0; t_acc = 0; t_out = 0; m_w = 0; m_exc = 0; m_to = 0;
    m_res = '0; m_a = '0; m_b = '0; m_op = '0; m_excout = '0; m_ures = '0;
    m_opc = 0; m_excc = 0; rq_v = 0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input bit ex, input logic [31:0] eo, input logic [31:0] ur, input int w);
    rq_v = 1; rq_a = a; rq_b = b; rq_op = op; rq_exc = ex; rq_excout = eo; rq_ures = ur; rq_w = w;
  endtask

  function automatic int rand_w();
    if (TO_EN && $urandom_range(0, 5) == 0) return int'($urandom_range(7, 12));
    return int'($urandom_range(0, 5));
  endfunction

  // One clock cycle: compare at the falling edge, then drive this cycle's inputs.
  task automatic run_cycle();
    int k;
    bit e_ov, e_us, allow_spur;
    @(negedge clk);
    k    = cyc - t_acc;
    e_ov = busy && (cyc >= t_out);
    e_us = busy && !m_exc && (k == 2);
    chk("in_ready",   32'(in_ready),   32'(!busy));
    chk("out_valid",  32'(out_valid),  32'(e_ov));
    chk("unit_start", 32'(unit_start), 32'(e_us));
    chk("op_a", op_a, m_a);
    chk("op_b", op_b, m_b);
    chk("op_code",   32'(op_code),   32'(m_op));
    chk("op_count",  32'(op_count),  32'(m_opc));
    chk("exc_count", 32'(exc_count), 32'(m_excc));
    if (e_ov) begin
      chk("result",       result,             m_res);
      chk("exc_flag",     32'(exc_flag),      32'(m_exc));
      chk("timeout_flag", 32'(timeout_flag),  32'(m_to));
    end
    if (busy) begin
      if (unit_start) obs_starts++;
      if (out_valid) begin
        obs_vcycles++;
        if (!obs_seen) begin
          obs_seen = 1; obs_lat = k; obs_res = result; obs_exc = exc_flag; obs_to = timeout_flag;
        end
      end
    end

    float_num1 = $urandom; float_num2 = $urandom; opcode = 2'($urandom);
    in_valid = 1'b0;
    if (rq_v) begin
      in_valid = 1'b1; float_num1 = rq_a; float_num2 = rq_b; opcode = rq_op;
    end else if (busy) begin
      in_valid = 1'($urandom);
    end
    if (busy && k == 1) begin
      exc_sel = m_exc; exc_out = m_excout;
    end else begin
      exc_sel = 1'($urandom); exc_out = $urandom;
    end
    unit_done = 1'b0; unit_result = $urandom;
    if (busy && !m_exc && m_w != NEVER && k == 2 + m_w) begin
      unit_done = 1'b1; unit_result = m_ures;
    end else begin
      allow_spur = !busy || m_exc || k < 2 || (m_w != NEVER && k > 2 + m_w);
      if (force_done || (allow_spur && $urandom_range(0, 3) == 0)) unit_done = 1'b1;
    end
    if (e_ov) begin
      if (obs_vcycles <= ready_low_n) out_ready = 1'b0;
      else if (rand_ready)            out_ready = 1'($urandom);
      else                            out_ready = 1'b1;
    end else begin
      out_ready = 1'($urandom);
    end

    if (!rst) begin
      if (e_ov && out_ready) begin
        if (m_opc < CMAX) m_opc++;
        if (m_exc && m_excc < CMAX) m_excc++;
        busy = 0; n_done++;
      end else if (!busy && in_valid) begin
        acc_gap = cyc - t_acc;
        busy = 1; t_acc = cyc; rq_v = 0;
        m_a = float_num1; m_b = float_num2; m_op = opcode;
        m_exc = rq_exc; m_excout = rq_excout; m_ures = rq_ures; m_w = rq_w;
        obs_seen = 0; obs_starts = 0; obs_vcycles = 0;
        if (m_exc) begin
          t_out = cyc + 2; m_res = m_excout; m_to = 0;
        end else if (m_w != NEVER && (!TO_EN || m_w <= TOC)) begin
          t_out = cyc + 3 + m_w; m_res = m_ures; m_to = 0;
        end else if (TO_EN) begin
          t_out = cyc + 3 + TOC; m_res = 32'h7FC0_0000; m_to = 1;
        end else begin
          t_out = 2147483647; m_res = '0; m_to = 0;
        end
      end
    end
    force_done = 0;
    cyc++;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while ((busy || rq_v) && n < budget) begin
      run_cycle();
      n++;
    end
    chk(name, 32'(busy || rq_v), 32'(0));
  endtask

  initial begin
    int n, base, first_acc;
    rst = 1'b1; in_valid = 0; float_num1 = '0; float_num2 = '0; opcode = '0;
    exc_sel = 0; exc_out = '0; unit_done = 0; unit_result = '0; out_ready = 0;
    model_reset();
    n_done = 0; acc_gap = 0; ready_low_n = 0; rand_ready = 1; force_done = 0;
    obs_lat = 0; obs_starts = 0; obs_vcycles = 0; obs_seen = 0; obs_exc = 0; obs_to = 0; obs_res = '0;
    repeat (3) run_cycle();
    rst = 1'b0;
    repeat (2) run_cycle();

    // Exception path: +inf + -inf -> qNaN
    rand_ready = 0;
    push(32'h7F80_0000, 32'hFF80_0000, 2'b00, 1, 32'h7FC0_0000, $urandom, 0);
    run_until_idle("inf_timeout", 50);
    chk("inf_latency", 32'(obs_lat), 32'(2));
    chk("inf_result", obs_res, 32'h7FC0_0000);
    chk("inf_exc_flag", 32'(obs_exc), 32'(1));
    chk("inf_unit_starts", 32'(obs_starts), 32'(0));
    $display("txn inf: lat=%0d result=%h exc=%0d starts=%0d", obs_lat, obs_res, obs_exc, obs_starts);

    // Normal path: 2.0 * 3.0, unit done 4 cycles after start
    push(32'h4000_0000, 32'h4040_0000, 2'b10, 0, $urandom, 32'h40C0_0000, 4);
    run_until_idle("mul_timeout", 50);
    chk("mul_latency", 32'(obs_lat), 32'(7));
    chk("mul_result", obs_res, 32'h40C0_0000);
    chk("mul_exc_flag", 32'(obs_exc), 32'(0));
    chk("mul_unit_starts", 32'(obs_starts), 32'(1));
    $display("txn mul: lat=%0d result=%h exc=%0d starts=%0d", obs_lat, obs_res, obs_exc, obs_starts);

    // Backpressure: consumer stalls 5 cycles while a second request waits
    ready_low_n = 5;
    base = n_done;
    push(32'h3F80_0000, 32'h0000_0000, 2'b11, 1, 32'h7F80_0000, $urandom, 0);
    n = 0;
    while (!busy && n < 20) begin run_cycle(); n++; end
    first_acc = t_acc;
    push(32'h3F80_0000, 32'h3F80_0000, 2'b00, 0, $urandom, 32'h4000_0000, 1);
    n = 0;
    while (n_done < base + 1 && n < 50) begin run_cycle(); n++; end
    chk("bp_valid_cycles", 32'(obs_vcycles), 32'(6));
    chk("bp_result", obs_res, 32'h7F80_0000);
    ready_low_n = 0;
    run_until_idle("bp_timeout", 50);
    chk("bp_next_accept_gap", 32'(acc_gap), 32'(8));
    chk("bp_second_result", obs_res, 32'h4000_0000);
    $display("txn backpressure: first_acc=%0d gap=%0d result=%h", first_acc, acc_gap, obs_res);

    // Randomised traffic
    rand_ready = 1;
    for (int i = 0; i < 600; i++) begin
      if (!rq_v && (busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1)))
        push($urandom, $urandom, 2'($urandom), $urandom_range(0, 2) == 0, $urandom, $urandom, rand_w());
      run_cycle();
    end
    run_until_idle("random_drain_timeout", 100);
    $display("txn random: ops_done=%0d op_count=%0d exc_count=%0d", n_done, op_count, exc_count);

    // Watchdog behaviour on a unit that never answers
    rand_ready = 0;
    push(32'h4000_0000, 32'h0000_0000, 2'b11, 0, $urandom, $urandom, NEVER);
`ifdef FPU_SEQ_TIMEOUT_EN
    run_until_idle("wd_timeout", 100);
    chk("wd_result", obs_res, 32'h7FC0_0000);
    chk("wd_timeout_flag", 32'(obs_to), 32'(1));
    chk("wd_exc_flag", 32'(obs_exc), 32'(0));
    chk("wd_latency", 32'(obs_lat), 32'(11));
    $display("txn watchdog: lat=%0d result=%h timeout=%0d", obs_lat, obs_res, obs_to);
`else
    repeat (100) run_cycle();
    chk("wd_still_waiting_valid", 32'(out_valid), 32'(0));
    chk("wd_still_waiting_ready", 32'(in_ready), 32'(0));
    chk("wd_unit_starts", 32'(obs_starts), 32'(1));
    $display("txn watchdog-off: still waiting after 100 cycles, out_valid=%0d", out_valid);
`endif

    // Reset in the middle of WAIT, then a late unit_done
    if (!busy) begin
      push(32'h4040_0000, 32'h4000_0000, 2'b01, 0, $urandom, $urandom, NEVER);
      n = 0;
      while (!(busy && cyc - t_acc == 5) && n < 50) begin run_cycle(); n++; end
    end
    rst = 1'b1;
    model_reset();
    repeat (2) run_cycle();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_unit_start", 32'(unit_start), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_op_count", 32'(op_count), 32'(0));
    rst = 1'b0;
    force_done = 1;
    repeat (4) run_cycle();
    chk("late_done_out_valid", 32'(out_valid), 32'(0));
    chk("late_done_op_count", 32'(op_count), 32'(0));
    $display("txn reset-mid-wait: out_valid=%0d in_ready=%0d op_count=%0d", out_valid, in_ready, op_count);

    // Back-to-back exception ops until both counters saturate
    base = n_done;
    n = 0;
    while (n_done < base + 20 && n < 300) begin
      if (!rq_v) push($urandom, $urandom, 2'($urandom), 1, $urandom, $urandom, 0);
      run_cycle();
      n++;
    end
    chk("b2b_accept_gap", 32'(acc_gap), 32'(3));
    rq_v = 0;
    run_until_idle("sat_timeout", 50);
    chk("sat_op_count", 32'(op_count), 32'(15));
    chk("sat_exc_count", 32'(exc_count), 32'(15));
    $display("txn saturation: op_count=%0d exc_count=%0d gap=%0d", op_count, exc_count, acc_gap);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
